digi_scan: RTL and testbench



---
 rtl/digi_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 38 +++
 rtl/digi_scan.sv | 109 ++++++++++
 tb/tb_digi_scan.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digi_pkg.sv
// -----------------------------------------------------------------------------
// digi_pkg
// Shared constants for the 7-segment display path.
//   - SEG_0 .. SEG_F : active-low {g,f,e,d,c,b,a} glyphs for hex 0-F
//   - SEG_BLANK      : all segments off
//   - DIGI_OFF       : {an, seg} value for a fully dark display
//   - write-data field offsets and a helper to pull one hex nibble
// -----------------------------------------------------------------------------
package digi_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int HEX_W      = 4;
   localparam int HEX_LSB    = 0;     // hex0 at [3:0] .. hex3 at [15:12]
   localparam int DP_LSB     = 16;    // dp[3:0] at [19:16]
   localparam int WR_W       = 20;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;   // 6 with the top tail (a) lit
   localparam logic [6:0] SEG_7 = 7'h78;   // a, b, c only
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;   // 9 with the bottom tail (d) lit
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;   // lower-case b
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;   // lower-case d
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [11:0] DIGI_OFF  = 12'hFFF;

   // Nibble k (0 = rightmost digit) of a write/display word.
   function automatic logic [3:0] hex_field(input logic [WR_W-1:0] v, input logic [1:0] k);
      return v[HEX_LSB + {k, 2'b00} +: HEX_W];
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex to 7-segment decoder, active-low outputs.
// Ports:
//   hex : in  4-bit value 0-F
//   seg : out 7-bit {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module seg7_decode
   import digi_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/digi_scan.sv
// -----------------------------------------------------------------------------
// digi_scan
// Time-multiplexed driver for a 4-digit 7-segment display. A CPU write lands
// in a pending buffer and is copied to the display register only when the scan
// wraps from digit 3 to digit 0, so a displayed frame is never torn.
//
// Parameters:
//   SCAN_DIV : clock cycles each digit is held (2 .. 2^20)
//   LZ_BLANK : 1 = blank leading zero digits (digit 0 is never blanked)
// Ports:
//   iClk     : in  system clock
//   iRst_n   : in  asynchronous active-low reset
//   iWr      : in  single-cycle write strobe; there is no back-pressure, every
//                  strobe is accepted and the last one before a commit wins
//   iWrData  : in  {dp[3:0], hex3, hex2, hex1, hex0}
//   oDigi    : out registered {an[3:0], seg[7:0]}, both active-low,
//                  seg = {dp, g, f, e, d, c, b, a}
//   oPending : out high while a written value waits for the next frame start
// -----------------------------------------------------------------------------
module digi_scan
   import digi_pkg::*;
#(
   parameter int SCAN_DIV = 25000,
   parameter bit LZ_BLANK = 1'b0
)
(
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iWr,
   input  logic [WR_W-1:0]   iWrData,
   output logic [11:0]       oDigi,
   output logic              oPending
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0]   cnt;
   logic [1:0]      idx;
   logic [WR_W-1:0] disp;
   logic [WR_W-1:0] pend;
   logic            pend_v;
   logic            run;

   logic            tick;
   logic [1:0]      idx_nxt;
   logic            commit;
   logic [WR_W-1:0] disp_nxt;
   logic [3:0]      hex_nxt;
   logic [6:0]      glyph_nxt;
   logic [3:0]      dp_bits;
   logic            blank_nxt;
   logic [11:0]     digi_nxt;

   assign tick     = (cnt == CNT_LAST);
   assign idx_nxt  = idx + 2'd1;
   assign commit   = tick && (idx == 2'd3) && pend_v;
   // Decode from the value in effect after this edge, so the digit-0 slot
   // starting at a commit already shows the new data.
   assign disp_nxt = commit ? pend : disp;
   assign hex_nxt  = hex_field(disp_nxt, idx_nxt);

   seg7_decode u_dec (
      .hex (hex_nxt),
      .seg (glyph_nxt)
   );

   always_comb begin
      dp_bits   = disp_nxt[DP_LSB +: NUM_DIGITS];
      // Digit k is a leading zero when nibbles k..3 are all zero.
      blank_nxt = LZ_BLANK && (idx_nxt != 2'd0) &&
                  ((disp_nxt[15:0] >> {idx_nxt, 2'b00}) == 16'h0000);
      digi_nxt  = {~(4'b0001 << idx_nxt),
                   ~dp_bits[idx_nxt],
                   blank_nxt ? SEG_BLANK : glyph_nxt};
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt    <= '0;
         idx    <= 2'd3;
         disp   <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
         run    <= 1'b0;
         oDigi  <= DIGI_OFF;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) begin
            idx   <= idx_nxt;
            run   <= 1'b1;
            oDigi <= digi_nxt;
         end
         if (commit)
            disp <= pend;
         // A write on the commit edge refills the buffer after the old value
         // has been taken, so the flag stays set for the next frame.
         if (iWr) begin
            pend   <= iWrData;
            pend_v <= 1'b1;
         end else if (commit) begin
            pend_v <= 1'b0;
         end
      end
   end

   assign oPending = pend_v;

endmodule

// File: tb/tb_digi_scan.sv
// -----------------------------------------------------------------------------
// tb_digi_scan
// Bench for digi_scan with SCAN_DIV = 4. Two instances share all inputs, one
// with leading-zero blanking off and one with it on.
// -----------------------------------------------------------------------------
module tb_digi_scan;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr;
   logic [19:0] wdata;
   logic [11:0] digi0, digi1;
   logic        pend0, pend1;

   always #5 clk = ~clk;

   digi_scan #(.SCAN_DIV(D), .LZ_BLANK(1'b0)) dut0 (
      .iClk(clk), .iRst_n(rst_n), .iWr(wr), .iWrData(wdata),
      .oDigi(digi0), .oPending(pend0)
   );

   digi_scan #(.SCAN_DIV(D), .LZ_BLANK(1'b1)) dut1 (
      .iClk(clk), .iRst_n(rst_n), .iWr(wr), .iWrData(wdata),
      .oDigi(digi1), .oPending(pend1)
   );

   int checks   = 0;
   int failures = 0;

   // Standard active-low glyphs {g,f,e,d,c,b,a} for 0-F.
   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // ---------------- reference model ----------------
   // Time is counted in clock edges since reset release; a digit slot lasts
   // D edges and the scan advances on every D-th edge.
   int          m_e;
   logic [19:0] m_disp, m_pend;
   logic        m_pv;
   logic [11:0] m_digi0, m_digi1;

   function automatic logic [11:0] expect_digit(input logic [19:0] v, input int k, input bit lz);
      logic [15:0] upper;
      logic [6:0]  s;
      logic [3:0]  an;
      upper = v[15:0] >> (4 * k);
      s     = GLYPH[upper[3:0]];
      if (lz && k > 0 && upper == 16'h0000) s = 7'h7F;
      an    = 4'hF & ~(4'b0001 << k);
      return {an, ~v[16 + k], s};
   endfunction

   task automatic model_reset();
      m_e     = 0;
      m_disp  = '0;
      m_pend  = '0;
      m_pv    = 1'b0;
      m_digi0 = 12'hFFF;
      m_digi1 = 12'hFFF;
   endtask

   task automatic model_edge(input logic w, input logic [19:0] d);
      int k;
      m_e++;
      if (m_e % D == 0) begin
         k = (3 + m_e / D) % 4;
         if (k == 0 && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
         end
         m_digi0 = expect_digit(m_disp, k, 1'b0);
         m_digi1 = expect_digit(m_disp, k, 1'b1);
      end
      if (w) begin
         m_pend = d;
         m_pv   = 1'b1;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, m_e);
      end
   endtask

   task automatic compare_model();
      chk("model_digi", {20'h0, digi0}, {20'h0, m_digi0});
      chk("model_digi_lz", {20'h0, digi1}, {20'h0, m_digi1});
      chk("model_pend", {31'h0, pend0}, {31'h0, m_pv});
      chk("model_pend_lz", {31'h0, pend1}, {31'h0, m_pv});
   endtask

   // Called at a falling edge: drive inputs, take one rising edge, advance the
   // model, then compare at the next falling edge.
   task automatic step(input logic w, input logic [19:0] d);
      wr    = w;
      wdata = d;
      @(posedge clk);
      model_edge(w, d);
      @(negedge clk);
      wr    = 1'b0;
      wdata = '0;
      compare_model();
   endtask

   task automatic run_to(input int target);
      while (m_e < target) step(1'b0, 20'h0);
   endtask

   task automatic check_at(input int target, input string name,
                           input logic [11:0] exp_digi, input logic exp_pend);
      run_to(target);
      chk(name, {20'h0, digi0}, {20'h0, exp_digi});
      chk({name, "_pend"}, {31'h0, pend0}, {31'h0, exp_pend});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        wr;
      logic [19:0] data;
      logic [11:0] exp_digi;
      logic        exp_pend;
   } vec_t;

   vec_t        tbl[20];
   logic [11:0] frame_seq[4];

   initial begin
      frame_seq[0] = 12'hEC0;
      frame_seq[1] = 12'hDC0;
      frame_seq[2] = 12'hBC0;
      frame_seq[3] = 12'h7C0;
      // Reset release with no writes: dark for the first slot, then the
      // all-zero frame scans digit 0,1,2,3.
      for (int i = 0; i < 20; i++) begin
         tbl[i].wr       = 1'b0;
         tbl[i].data     = 20'h0;
         tbl[i].exp_pend = 1'b0;
         tbl[i].exp_digi = (i + 1 < D) ? 12'hFFF : frame_seq[((i + 1) / D - 1) % 4];
      end

      // Reset with a write strobe held: the strobe must be ignored.
      model_reset();
      rst_n = 1'b0;
      wr    = 1'b1;
      wdata = 20'hF_FFFF;
      repeat (2) @(negedge clk);
      chk("rst_digi", {20'h0, digi0}, 32'hFFF);
      chk("rst_digi_lz", {20'h0, digi1}, 32'hFFF);
      chk("rst_pend", {31'h0, pend0}, 32'h0);
      wr    = 1'b0;
      wdata = '0;
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].wr, tbl[i].data);
         chk("tbl_digi", {20'h0, digi0}, {20'h0, tbl[i].exp_digi});
         chk("tbl_pend", {31'h0, pend0}, {31'h0, tbl[i].exp_pend});
      end

      // Write 0_1234 while digit 1 is showing; frame finishes with zeros.
      run_to(25);
      step(1'b1, 20'h0_1234);
      chk("wr1234_pend", {31'h0, pend0}, 32'h1);
      check_at(28, "wr1234_old2", 12'hBC0, 1'b1);
      check_at(32, "wr1234_old3", 12'h7C0, 1'b1);
      check_at(36, "wr1234_d0", 12'hE99, 1'b0);
      check_at(40, "wr1234_d1", 12'hDB0, 1'b0);
      check_at(44, "wr1234_d2", 12'hBA4, 1'b0);
      check_at(48, "wr1234_d3", 12'h7F9, 1'b0);

      // All decimal points on with hex letters.
      run_to(49);
      step(1'b1, 20'hF_ABCD);
      check_at(52, "abcd_d0", 12'hE21, 1'b0);
      check_at(64, "abcd_d3", 12'h708, 1'b0);

      // Two writes in one frame: only the second is ever shown.
      run_to(69);
      step(1'b1, 20'h0_1111);
      run_to(71);
      step(1'b1, 20'h0_2222);
      check_at(84, "last_wins_d0", 12'hEA4, 1'b0);
      check_at(88, "last_wins_d1", 12'hDA4, 1'b0);

      // Write landing exactly on the commit edge.
      run_to(89);
      step(1'b1, 20'h0_5555);
      run_to(99);
      step(1'b1, 20'h0_6666);
      chk("same_edge_d0", {20'h0, digi0}, 32'hE92);
      chk("same_edge_pend", {31'h0, pend0}, 32'h1);
      check_at(112, "same_edge_hold", 12'h792, 1'b1);
      check_at(116, "same_edge_next", 12'hE82, 1'b0);

      // Leading-zero blanking on the second instance.
      run_to(119);
      step(1'b1, 20'h0_0050);
      run_to(132);
      chk("lz_d0", {20'h0, digi1}, 32'hEC0);
      run_to(136);
      chk("lz_d1", {20'h0, digi1}, 32'hD92);
      run_to(140);
      chk("lz_d2", {20'h0, digi1}, 32'hBFF);
      chk("nolz_d2", {20'h0, digi0}, 32'hBC0);
      run_to(144);
      chk("lz_d3", {20'h0, digi1}, 32'h7FF);

      // Reset mid-frame with a write pending.
      run_to(149);
      step(1'b1, 20'hF_9876);
      run_to(153);
      rst_n = 1'b0;
      #1;
      chk("async_rst_digi", {20'h0, digi0}, 32'hFFF);
      chk("async_rst_digi_lz", {20'h0, digi1}, 32'hFFF);
      chk("async_rst_pend", {31'h0, pend0}, 32'h0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      check_at(3, "post_rst_dark", 12'hFFF, 1'b0);
      check_at(4, "post_rst_d0", 12'hEC0, 1'b0);
      check_at(20, "post_rst_lost", 12'hEC0, 1'b0);

      // Random writes checked every cycle against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0)
            step(1'b1, 20'($urandom));
         else
            step(1'b0, 20'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
